// File: rtl/region_pantalla_pkg.sv
// Shared types and colour helpers for the scaled VGA region colour stage.
package region_pantalla_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Per-pixel control carried alongside the framebuffer read.
  typedef struct packed {
    logic valid;
    logic in_region;
    logic mode;
  } pix_ctl_t;

  localparam rgb_t RGB_BLACK = '0;

  // A set bit turns its channel off; only the low three bits are used.
  function automatic rgb_t direct_color(input logic [2:0] idx);
    rgb_t c;
    c.r = idx[0] ? 8'h00 : 8'hFF;
    c.g = idx[1] ? 8'h00 : 8'hFF;
    c.b = idx[2] ? 8'h00 : 8'hFF;
    return c;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with asynchronous clear.
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/region_pantalla_scaled.sv
// Beam position to framebuffer address with integer scaling, then
// latency-aligned mapping of the returned word to RGB (direct or palette).
module region_pantalla_scaled
  import region_pantalla_pkg::*;
#(
  parameter int unsigned ColorBits   = 3,
  parameter int unsigned screenX     = 320,
  parameter int unsigned screenY     = 240,
  parameter int unsigned ScaleShift  = 1,
  parameter int unsigned MemLatency  = 1,
  parameter int unsigned AddrBits    = 17,
  parameter logic [23:0] BorderColor = 24'hFFFFFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           posicionX,
  input  logic [9:0]           posicionY,
  input  logic                 pixelValid,
  input  logic                 mode,
  output logic [AddrBits-1:0]  memAddr,
  input  logic [ColorBits-1:0] readValueMemory,
  input  logic                 paletteWe,
  input  logic [ColorBits-1:0] paletteIdx,
  input  logic [23:0]          paletteData,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 pixelValidOut
);

  localparam int unsigned AW      = AddrBits + 1;
  localparam int unsigned PalSize = 1 << ColorBits;

  logic [9:0]          sx;
  logic [9:0]          sy;
  logic                in_region;
  logic [AddrBits-1:0] addr_d, addr_q;
  pix_ctl_t            ctl_a_d, ctl_a_q, ctl_c;
  rgb_t                rgb_d, rgb_q;
  logic                vout_d, vout_q;
  rgb_t                palette_d [PalSize];
  rgb_t                palette_q [PalSize];

  // Stage A: scaled coordinates and linear address
  always_comb begin
    sx        = posicionX >> ScaleShift;
    sy        = posicionY >> ScaleShift;
    in_region = (32'(sx) < screenX) && (32'(sy) < screenY);
    addr_d    = '0;
    if (in_region && pixelValid) begin
      addr_d = AddrBits'(AW'(sy) * AW'(screenX) + AW'(sx));
    end
    ctl_a_d = '{valid: pixelValid, in_region: in_region, mode: mode};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      ctl_a_q <= '0;
    end else begin
      addr_q  <= addr_d;
      ctl_a_q <= ctl_a_d;
    end
  end

  // Control travels with the memory request so it meets the returned word.
  pipe_delay #(
    .WIDTH ($bits(pix_ctl_t)),
    .DEPTH (MemLatency)
  ) u_ctl_delay (
    .clk  (clock),
    .rst  (reset),
    .din  (ctl_a_q),
    .dout (ctl_c)
  );

  always_comb begin
    palette_d = palette_q;
    if (paletteWe) begin
      palette_d[paletteIdx] = rgb_t'(paletteData);
    end
  end

  // Reset restores the legacy direct-mode colours into every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PalSize; i++) begin
        palette_q[i] <= direct_color(3'(i));
      end
    end else begin
      palette_q <= palette_d;
    end
  end

  // Stage C: lookup reads the pre-write palette, giving read-before-write.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (ctl_c.valid) begin
      if (!ctl_c.in_region) begin
        rgb_d = rgb_t'(BorderColor);
      end else if (ctl_c.mode) begin
        rgb_d = palette_q[readValueMemory];
      end else begin
        rgb_d = direct_color(readValueMemory[2:0]);
      end
    end
    vout_d = ctl_c.valid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q  <= RGB_BLACK;
      vout_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      vout_q <= vout_d;
    end
  end

  assign memAddr       = addr_q;
  assign red           = rgb_q.r;
  assign green         = rgb_q.g;
  assign blue          = rgb_q.b;
  assign pixelValidOut = vout_q;

endmodule

// File: tb/tb_region_pantalla_scaled.sv
// Scoreboard bench: four DUT copies (MemLatency 1..4) share stimulus and memory.
module tb_region_pantalla_scaled;

  localparam int unsigned NPIX = 320 * 240;

  typedef struct packed {
    logic [31:0] due;
    logic        pv;
    logic        inr;
    logic        md;
    logic [2:0]  idx;
  } exp_t;

  typedef struct packed {
    logic [31:0] due;
    logic [16:0] addr;
  } aexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic        pv = 1'b0;
  logic        md = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  widx = '0;
  logic [23:0] wdata = '0;

  logic [2:0]  mem [NPIX];
  logic [23:0] pal_model [8];
  logic [23:0] pal_before [8];
  logic [31:0] cyc = '0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sbq [4][$];
  aexp_t       aq [$];
  aexp_t       a_chk;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] dcol(input logic [2:0] i);
    return {i[0] ? 8'h00 : 8'hFF, i[1] ? 8'h00 : 8'hFF, i[2] ? 8'h00 : 8'hFF};
  endfunction

  // Palette reference; pal_before holds the contents prior to the latest edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pal_model[i]  <= dcol(3'(i));
        pal_before[i] <= dcol(3'(i));
      end
    end else begin
      pal_before <= pal_model;
      if (we) pal_model[widx] <= wdata;
    end
  end

  function automatic logic [23:0] exp_rgb(input exp_t e);
    if (!e.pv) return 24'h000000;
    if (!e.inr) return 24'hFFFFFF;
    if (e.md) return pal_before[e.idx];
    return dcol(e.idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic v, input logic m,
                       input logic w = 1'b0, input logic [2:0] wi = 3'd0,
                       input logic [23:0] wd = 24'h0);
    exp_t        e;
    aexp_t       a;
    int unsigned sx, sy, ad;
    logic        inr;
    @(negedge clk);
    px = 10'(x); py = 10'(y); pv = v; md = m;
    we = w; widx = wi; wdata = wd;
    sx  = x / 2;
    sy  = y / 2;
    inr = (sx < 320) && (sy < 240);
    ad  = (v && inr) ? sy * 320 + sx : 0;
    a.due  = cyc + 1;
    a.addr = 17'(ad);
    aq.push_back(a);
    for (int g = 0; g < 4; g++) begin
      e.due = cyc + 32'(g) + 3;
      e.pv  = v;
      e.inr = inr;
      e.md  = m;
      e.idx = mem[ad];
      sbq[g].push_back(e);
    end
  endtask

  task automatic flush();
    for (int g = 0; g < 4; g++) sbq[g].delete();
    aq.delete();
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [16:0] addr;
    logic [2:0]  rd;
    logic [7:0]  r, gr, b;
    logic        pvo;
    logic [2:0]  rpipe [g+1];
    exp_t        e;

    assign rd = rpipe[g];

    always @(posedge clk) begin
      rpipe[0] <= mem[addr];
      for (int k = 1; k <= g; k++) rpipe[k] <= rpipe[k-1];
    end

    region_pantalla_scaled #(.MemLatency(g + 1)) u_dut (
      .clock           (clk),
      .reset           (rst),
      .posicionX       (px),
      .posicionY       (py),
      .pixelValid      (pv),
      .mode            (md),
      .memAddr         (addr),
      .readValueMemory (rd),
      .paletteWe       (we),
      .paletteIdx      (widx),
      .paletteData     (wdata),
      .red             (r),
      .green           (gr),
      .blue            (b),
      .pixelValidOut   (pvo)
    );

    always @(negedge clk) begin
      if (!rst && sbq[g].size() > 0 && sbq[g][0].due == cyc) begin
        e = sbq[g].pop_front();
        check($sformatf("rgb_lat%0d", g + 1), {8'h00, r, gr, b}, {8'h00, exp_rgb(e)});
        check($sformatf("pvo_lat%0d", g + 1), 32'(pvo), 32'(e.pv));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && aq.size() > 0 && aq[0].due == cyc) begin
      a_chk = aq.pop_front();
      check("memaddr", 32'(g_dut[0].addr), 32'(a_chk.addr));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 3'($urandom);
    repeat (3) @(negedge clk);
    check("rst_rgb",  {8'h00, g_dut[0].r, g_dut[0].gr, g_dut[0].b}, 32'h0);
    check("rst_pvo",  32'(g_dut[0].pvo), 32'h0);
    check("rst_addr", 32'(g_dut[0].addr), 32'h0);
    rst = 1'b0;

    for (int x = 0; x < 12; x++) drive(x * 8, 4, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    flush();
    #1;
    check("midrst_rgb0", {8'h00, g_dut[0].r, g_dut[0].gr, g_dut[0].b}, 32'h0);
    check("midrst_pvo0", 32'(g_dut[0].pvo), 32'h0);
    check("midrst_rgb3", {8'h00, g_dut[3].r, g_dut[3].gr, g_dut[3].b}, 32'h0);
    check("midrst_addr", 32'(g_dut[0].addr), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    mem[0] = 3'b000;
    drive(0, 0, 1'b1, 1'b0);
    mem[1605] = 3'b101;
    drive(10, 10, 1'b1, 1'b0);

    mem[319] = 3'b010;
    for (int x = 638; x <= 641; x++) drive(x, 0, 1'b1, 1'b0);
    drive(5, 5, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 3'd5, 24'h123456);
    drive(10, 10, 1'b1, 1'b1);
    drive(10, 10, 1'b1, 1'b1);
    drive(10, 10, 1'b1, 1'b1);
    drive(10, 10, 1'b1, 1'b1, 1'b1, 3'd5, 24'hABCDEF);
    drive(10, 10, 1'b1, 1'b1);
    drive(10, 10, 1'b1, 1'b1);

    drive(0, 0, 1'b0, 1'b0, 1'b1, 3'd1, 24'h0000FF);
    for (int i = 320; i < 328; i++) mem[i] = 3'b001;
    for (int x = 0; x < 16; x++) drive(x, 2, 1'b1, 1'(x % 2));

    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 3'($urandom), 24'($urandom));
    end

    @(negedge clk);
    pv = 1'b0; we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() + aq.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() + aq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/region_pantalla_scaled.md
Name: region_pantalla_scaled

Overview:
- Parametrised successor of the VGA region colour stage.
- Generates the framebuffer read address from the beam position, with integer pixel scaling. Aligns the returned memory word with the beam through a latency-matched pipeline.
- Maps the word to 24-bit RGB in one of two modes:
  - direct: per-bit on/off, legacy-compatible;
  - palette: writable 2^ColorBits-entry LUT.
- Sits between the VGA timing generator / framebuffer RAM and the DAC output registers.

Parameters:
- ColorBits, 3, bits per framebuffer pixel; legal range 3..8.
- screenX, 320, framebuffer width in stored pixels.
- screenY, 240, framebuffer height in stored pixels.
- ScaleShift, 1, each stored pixel is shown as a 2^ScaleShift x 2^ScaleShift block.
- MemLatency, 1, cycles from memAddr to readValueMemory valid; legal range 1..4.
- AddrBits, 17, width of memAddr; must satisfy 2^AddrBits >= screenX*screenY.
- BorderColor, 24'hFFFFFF, RGB shown for active pixels outside the region.

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- posicionX  in  10  beam column
- posicionY  in  10  beam row
- pixelValid  in  1  beam is in active video
- mode  in  1  0 = direct, 1 = palette; sampled with the pixel at the address stage
- memAddr  out  AddrBits  framebuffer read address
- readValueMemory  in  ColorBits  framebuffer data, valid MemLatency cycles after memAddr
- paletteWe  in  1  palette write strobe
- paletteIdx  in  ColorBits  palette entry to write
- paletteData  in  24  RGB value to write, as {R,G,B}
- red  out  8  red channel
- green  out  8  green channel
- blue  out  8  blue channel
- pixelValidOut  out  1  pixelValid delayed to align with RGB

Behaviour:
- Reset: asynchronous, active-high.
  - memAddr, red, green, blue and pixelValidOut = 0.
  - All pipeline stages are cleared (valid = 0).
  - Palette entry i is reloaded with the direct-mode colour of i.
- Stage A (address), registered:
  - sx = posicionX >> ScaleShift; sy = posicionY >> ScaleShift.
  - inRegion = (sx < screenX) && (sy < screenY).
  - memAddr = sy*screenX + sx when inRegion && pixelValid; otherwise memAddr = 0.
  - Arithmetic is done at AddrBits+1 width, then truncated.
- Delay line: {pixelValid, inRegion, mode} is delayed MemLatency cycles so it arrives together with readValueMemory.
- Stage C (colour), registered:
  - pixelValid = 0: RGB = 0 (blanking).
  - pixelValid = 1, outside region: RGB = BorderColor.
  - pixelValid = 1, inside region, direct mode, using bits [2:0] only:
    - red = bit0 ? 00 : FF;
    - green = bit1 ? 00 : FF;
    - blue = bit2 ? 00 : FF.
  - pixelValid = 1, inside region, palette mode: RGB = palette[readValueMemory].
- Latency: RGB and pixelValidOut change MemLatency+2 cycles after posicionX/Y. Fully pipelined, one pixel per clock, no stalls.
- Palette write:
  - Updates the entry on the clock edge where paletteWe = 1.
  - Visible to stage-C lookups from the next cycle onward.
  - A lookup of the same index in the write cycle returns the old value (read-before-write).
- Scaling: with ScaleShift = 1, columns 0 and 1 give the same address. The last region column is 2*screenX-1; column 2*screenX is border.
- Mode change mid-line: takes effect per pixel, exactly aligned to that pixel's address stage, with no glitch on other pixels.
- Reset mid-frame:
  - Outputs go to 0 immediately.
  - After release, the first valid RGB appears MemLatency+2 cycles after the first sample.
  - Any palette writes made before reset are lost.

Decomposition:
- Package region_pantalla_pkg:
  - rgb_t: packed struct {r, g, b}, 8 bits each.
  - RGB_BLACK constant.
  - function direct_color(idx) returning rgb_t; used for direct mode and for palette reset values.
- Sub-module pipe_delay:
  - Parameters WIDTH and DEPTH.
  - Async reset to 0.
  - Used for the MemLatency control delay line.

Test Plan:
- Reset asserted mid-line -> RGB = 0 and pixelValidOut = 0 in the same cycle. After release with X=0, Y=0, pixelValid=1, direct mode, mem=3'b000 -> RGB = FFFFFF at cycle MemLatency+2.
- Direct mode, mem=3'b101 at X=10, Y=10 -> RGB = 00FF00 (R=00, G=FF, B=00). Also check memAddr = 5*320+5 = 1605 with ScaleShift=1.
- Scan X=638..641, Y=0 (ScaleShift=1) -> memAddr 319, 319, 0, 0. RGB shows pixel, pixel, BorderColor, BorderColor. pixelValid=0 -> RGB = 000000.
- Palette mode: write idx 5 = 123456, then read idx 5 -> RGB = 123456. Write and lookup of idx 5 in the same cycle -> old value, then new value on the next pixel.
- Sweep MemLatency = 1..4 with a random address/data model -> RGB always matches the reference model MemLatency+2 cycles later.
- Toggle mode every pixel with mem = 3'b001 and palette[1] = 0000FF -> outputs alternate 00FFFF and 0000FF, exactly aligned to each pixel.
